// File: rtl/i2c_eeprom_slave_if.sv
// i2c_eeprom_slave_if: serial lines and status flags of the EEPROM responder
interface i2c_eeprom_slave_if;
  logic SCL;
  logic SDA_IN;
  logic SDA_OE;
  logic BUSY;
  logic WR_DONE;
  modport master (output SCL, SDA_IN, input SDA_OE, BUSY, WR_DONE);
  modport slave (input SCL, SDA_IN, output SDA_OE, BUSY, WR_DONE);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C responder emulating a 24C16-style serial EEPROM
module i2c_eeprom_slave #(
  parameter int ADDR_W = 11,
  parameter logic [3:0] DEV_CODE = 4'b1010
) (
  input logic CLK,
  input logic RESET,
  i2c_eeprom_slave_if.slave bus
);
  typedef enum logic [3:0] {IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE} state_t;
  state_t state;
  logic [1:0] scl_s, sda_s;
  logic scl_h, sda_h;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] ptr;
  logic [3:0] cnt;
  logic [6:0] sr;
  logic [7:0] tx, rdq, byte_in;
  logic sda_oe, busy, wr_done;
  logic scl, sda, scl_r, scl_f, start, stop, we;
  assign scl = scl_s[1];
  assign sda = sda_s[1];
  assign scl_r = scl & ~scl_h;
  assign scl_f = ~scl & scl_h;
  assign start = scl & scl_h & sda_h & ~sda;
  assign stop = scl & scl_h & ~sda_h & sda;
  assign byte_in = {sr, sda};
  assign we = RESET & state == WDATA & scl_r & cnt == 4'd7;
  assign bus.SDA_OE = sda_oe;
  assign bus.BUSY = busy;
  assign bus.WR_DONE = wr_done;
  // two-flop synchronizers plus a history flop for edge detection
  always_ff @(posedge CLK) begin
    scl_s <= {scl_s[0], bus.SCL};
    sda_s <= {sda_s[0], bus.SDA_IN};
    scl_h <= scl;
    sda_h <= sda;
  end
  // storage array with a registered read port that tracks the pointer
  always_ff @(posedge CLK) begin
    if (we) mem[ptr] <= byte_in;
    rdq <= mem[ptr];
  end
  // protocol state machine; ACK and read bits only ever change on SCL fall
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= we;
      if (start) begin
        state <= CTRL;
        cnt <= '0;
        sda_oe <= 1'b0;
        busy <= 1'b1;
      end else if (stop) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          CTRL, ADDR, WDATA: if (scl_r) begin
            sr <= byte_in[6:0];
            cnt <= cnt + 1'b1;
            if (cnt == 4'd7) begin
              state <= state == CTRL ? (byte_in[7:4] == DEV_CODE ? CTRL_ACK : IGNORE) : state == ADDR ? ADDR_ACK : WDATA_ACK;
              if (state == ADDR) ptr[7:0] <= byte_in;
              if (state == WDATA) ptr <= ptr + 1'b1;
            end
          end
          CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_f) begin
            if (cnt == 4'd8) begin
              sda_oe <= 1'b1;
              cnt <= 4'd9;
              if (state == CTRL_ACK && sr[0]) begin
                tx <= rdq;
                ptr <= ptr + 1'b1;
              end
            end else begin
              cnt <= '0;
              if (state == CTRL_ACK && sr[0]) begin
                sda_oe <= ~tx[7];
                tx <= {tx[6:0], 1'b0};
                state <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state <= state == CTRL_ACK ? ADDR : WDATA;
                if (state == CTRL_ACK) ptr[ADDR_W-1:8] <= sr[ADDR_W-8:1];
              end
            end
          end
          RDATA: begin
            if (scl_f) begin
              sda_oe <= ~tx[7];
              tx <= {tx[6:0], 1'b0};
            end
            if (scl_r) begin
              cnt <= cnt + 1'b1;
              if (cnt == 4'd7) state <= MACK;
            end
          end
          MACK: begin
            if (scl_f && cnt == 4'd8) begin
              sda_oe <= 1'b0;
              cnt <= 4'd9;
            end
            if (scl_r && cnt == 4'd9) begin
              cnt <= '0;
              if (sda) state <= IGNORE;
              else begin
                tx <= rdq;
                ptr <= ptr + 1'b1;
                state <= RDATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bus-level master with a byte-array EEPROM reference model
module tb_i2c_eeprom_slave;
  logic CLK = 1'b0, RESET = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic line;
  int checks = 0, errors = 0, wr_cnt = 0, ptr = 0;
  logic [7:0] mm [2048];
  bit known [2048];
  typedef struct { logic [7:0] ctl, addr, data; logic ack; } vec_t;
  vec_t tab [8];
  i2c_eeprom_slave_if bus();
  assign line = sda_m & ~bus.SDA_OE;
  assign bus.SCL = scl;
  assign bus.SDA_IN = line;
  i2c_eeprom_slave dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  // every CLK with WR_DONE high counts, so a stretched pulse shows as extra writes
  always @(negedge CLK) if (bus.WR_DONE) wr_cnt++;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; tick(5); scl = 1'b1; tick(5); s = line; tick(5); scl = 1'b0; tick(5);
  endtask
  task automatic start_c;
    sda_m = 1'b1; tick(5); scl = 1'b1; tick(5); sda_m = 1'b0; tick(5); scl = 1'b0; tick(5);
  endtask
  task automatic stop_c;
    sda_m = 1'b0; tick(5); scl = 1'b1; tick(5); sda_m = 1'b1; tick(10);
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, s);
  endtask
  task automatic xfer_write(input logic [7:0] ctl, input logic [7:0] addr, input logic [7:0] d [$], input logic exp_ack);
    logic a;
    int w0;
    w0 = wr_cnt;
    start_c;
    chk("busy_after_start", int'(bus.BUSY), 1);
    wr_byte(ctl, a); chk("wr_ctl_ack", int'(a), int'(exp_ack));
    wr_byte(addr, a); chk("wr_addr_ack", int'(a), int'(exp_ack));
    foreach (d[i]) begin
      wr_byte(d[i], a); chk("wr_data_ack", int'(a), int'(exp_ack));
    end
    stop_c;
    chk("wr_done_count", wr_cnt - w0, exp_ack ? d.size() : 0);
    chk("busy_after_stop", int'(bus.BUSY), 0);
    if (ctl[7:4] == 4'hA) begin
      ptr = int'({ctl[3:1], addr});
      foreach (d[i]) begin
        mm[ptr] = d[i];
        known[ptr] = 1'b1;
        ptr = (ptr + 1) % 2048;
      end
    end
  endtask
  task automatic xfer_read(input logic [7:0] ctl, input logic [7:0] addr, input logic rnd, input int n);
    logic a;
    logic [7:0] d;
    start_c;
    if (rnd) begin
      wr_byte(ctl & 8'hFE, a); chk("rd_wctl_ack", int'(a), 1);
      wr_byte(addr, a); chk("rd_addr_ack", int'(a), 1);
      start_c;
      ptr = int'({ctl[3:1], addr});
    end
    wr_byte(ctl | 8'h01, a); chk("rd_ctl_ack", int'(a), 1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      if (known[ptr]) chk("rd_data", int'(d), int'(mm[ptr]));
      ptr = (ptr + 1) % 2048;
    end
    stop_c;
    chk("rd_release", int'(bus.SDA_OE), 0);
  endtask
  initial begin
    logic [7:0] q [$];
    logic [10:0] b;
    logic a;
    int w0;
    tab[0] = '{8'hA6, 8'hC6, 8'h6B, 1'b1};
    tab[1] = '{8'hA6, 8'hC5, 8'h5A, 1'b1};
    tab[2] = '{8'hA0, 8'h10, 8'h77, 1'b1};
    tab[3] = '{8'hA4, 8'h55, 8'h00, 1'b1};
    tab[4] = '{8'hB0, 8'h10, 8'hEE, 1'b0};
    tab[5] = '{8'hA2, 8'h80, 8'hC3, 1'b1};
    tab[6] = '{8'h22, 8'h80, 8'hFF, 1'b0};
    tab[7] = '{8'hAC, 8'h01, 8'h96, 1'b1};
    tick(4);
    chk("reset_sda_oe", int'(bus.SDA_OE), 0);
    chk("reset_busy", int'(bus.BUSY), 0);
    chk("reset_wr_done", int'(bus.WR_DONE), 0);
    RESET = 1'b1;
    tick(20);
    for (int i = 0; i < 8; i++) begin
      q.delete();
      q.push_back(tab[i].data);
      xfer_write(tab[i].ctl, tab[i].addr, q, tab[i].ack);
      xfer_read({4'hA, tab[i].ctl[3:1], 1'b0}, tab[i].addr, 1'b1, 1);
    end
    xfer_read(8'hA6, 8'hC5, 1'b1, 1);
    xfer_read(8'hA7, 8'h00, 1'b0, 1);
    q.delete(); q.push_back(8'h11); q.push_back(8'h22);
    xfer_write(8'hAE, 8'hFF, q, 1'b1);
    xfer_read(8'hAE, 8'hFF, 1'b1, 2);
    w0 = wr_cnt;
    start_c;
    wr_byte(8'hA0, a); chk("abort_ctl_ack", int'(a), 1);
    wr_byte(8'h10, a); chk("abort_addr_ack", int'(a), 1);
    for (int i = 0; i < 4; i++) clk_bit(i[0], a);
    stop_c;
    ptr = 16;
    chk("abort_wr_done", wr_cnt - w0, 0);
    chk("abort_busy", int'(bus.BUSY), 0);
    xfer_read(8'hA0, 8'h10, 1'b1, 1);
    start_c;
    wr_byte(8'hA4, a); chk("rst_ctl_ack", int'(a), 1);
    wr_byte(8'h55, a); chk("rst_addr_ack", int'(a), 1);
    start_c;
    wr_byte(8'hA5, a); chk("rst_rctl_ack", int'(a), 1);
    chk("rst_bit_driven", int'(bus.SDA_OE), 1);
    RESET = 1'b0;
    tick(1);
    chk("rst_sda_oe", int'(bus.SDA_OE), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    RESET = 1'b1;
    ptr = 0;
    stop_c;
    xfer_read(8'hA1, 8'h00, 1'b0, 1);
    q.delete(); q.push_back(8'h99);
    xfer_write(8'hA8, 8'h3D, q, 1'b1);
    xfer_read(8'hA8, 8'h3D, 1'b1, 1);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    xfer_write(8'hAE, 8'hF8, q, 1'b1);
    for (int t = 0; t < 16; t++) begin
      b = 11'((2040 + $urandom_range(0, 15)) % 2048);
      case ($urandom_range(0, 3))
        0: begin
          q.delete();
          for (int i = 0; i < int'($urandom_range(1, 4)); i++) q.push_back(8'($urandom));
          if ($urandom_range(0, 3) == 0) xfer_write({4'hE, b[10:8], 1'b0}, b[7:0], q, 1'b0);
          else xfer_write({4'hA, b[10:8], 1'b0}, b[7:0], q, 1'b1);
        end
        1, 2: xfer_read({4'hA, b[10:8], 1'b0}, b[7:0], 1'b1, int'($urandom_range(1, 3)));
        default: xfer_read({4'hA, b[10:8], 1'b1}, 8'h00, 1'b0, int'($urandom_range(1, 2)));
      endcase
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

- Synthesizable I2C responder that emulates a 24C16-style serial EEPROM with 2^ADDR_W bytes of internal storage.
- It is the far end of the serial link driven by the parallel-to-I2C write/read converter.
- It acknowledges its device code, takes page bits from the control byte and the low byte from the word-address byte, and supports byte/sequential write, current-address read and random read.
- Both serial lines are oversampled on the system clock; SDA is driven open-drain.

## Interface
- ADDR_W, 11: memory address width; bits [ADDR_W-1:8] come from control-byte bits [3:1].
- DEV_CODE, 4'b1010: device code matched against control-byte bits [7:4].
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  reset, synchronous, active-low.
- SCL  input  1  I2C clock from master, asynchronous.
- SDA_IN  input  1  sampled SDA line, asynchronous.
- SDA_OE  output  1  1 = pull SDA low; 0 = release (external pull-up).
- BUSY  output  1  high from START detect until STOP or IDLE.
- WR_DONE  output  1  one-CLK pulse when a data byte is written to memory.

## Operation
- SCL and SDA_IN each pass through a 2-flop synchronizer plus one history flop.
- Edge events:
  - SCL rise/fall: change in synchronized SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- START has priority over every state, including a repeated START mid-byte: go to CTRL, clear bit count, release SDA.
- STOP in any state: go to IDLE, release SDA. Nothing is written for a partial byte.
- States:
  - IDLE: wait for START.
  - CTRL: shift 8 bits MSB-first on SCL rise. Code match → CTRL_ACK. Mismatch → IGNORE, no ACK.
  - CTRL_ACK: drive ACK.
    - R/W=0: load ptr[ADDR_W-1:8] from control byte, go to ADDR.
    - R/W=1: load tx shift register with mem[ptr], ptr++, go to RDATA. Page bits are ignored.
  - ADDR: shift 8 bits, then ADDR_ACK. ptr[7:0] is loaded on the 8th SCL rise.
  - ADDR_ACK: drive ACK, then WDATA.
  - WDATA: shift 8 bits. On the 8th SCL rise write mem[ptr], ptr++, pulse WR_DONE, then WDATA_ACK.
  - WDATA_ACK: drive ACK, then WDATA (sequential write).
  - RDATA: drive tx bits MSB-first (SDA_OE = ~bit), then MACK.
  - MACK: release SDA, sample master bit on SCL rise.
    - 0 (ACK): reload tx from mem[ptr], ptr++, go to RDATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer arithmetic: ADDR_W bits, wraps 2^ADDR_W-1 → 0. Applies to both write and read increments, across pages.
- ACK drive rules:
  - SDA_OE=1 is set on the SCL fall after the 8th bit, cleared on the SCL fall after the 9th.
  - Read data bits also change only on SCL fall.
  - The first read bit is driven on the SCL fall ending CTRL_ACK.
- Reset values: SDA_OE=0, BUSY=0, WR_DONE=0, state IDLE, ptr=0, bit count 0, shift registers 0. Memory contents are not reset.
- RESET low mid-transfer: SDA_OE=0 at the next CLK edge and the state machine returns to IDLE. The slave then ignores the bus until the next START.

## Timing
- Pin change to detected event: 3 CLK.
- Detected SCL fall to SDA_OE change: 1 CLK, so 4 CLK from the SCL pin.
- Master constraints:
  - SCL high and low phases ≥ 8 CLK each.
  - SDA setup before SCL rise ≥ 4 CLK.
  - SDA hold after SCL fall ≥ 4 CLK.
- START/STOP are recognized only while synchronized SCL is high; an SDA glitch shorter than 1 CLK may be missed.
- WR_DONE asserts 1 CLK after the detected 8th SCL rise of a data byte, for exactly 1 CLK.
- Memory is written on that same edge.
- Memory read for tx load is synchronous. The data is valid before the next SCL fall, guaranteed by the 8-CLK low/high minimum.
- BUSY rises 1 CLK after START detect. It falls 1 CLK after STOP detect or on entry to IDLE.

## Test plan
- Byte write: START, 0xA6, 0xC5, 0x5A, STOP → ACK (SDA_OE=1) during each 9th clock, one WR_DONE pulse, mem[0x3C5]=0x5A, BUSY=0 after STOP.
- Random read: START, 0xA6, 0xC5, repeated START, 0xA7 → ACKs, slave drives 0x5A MSB-first; master NACK then STOP → SDA_OE=0, ptr=0x3C6.
- Wrong device code: START, 0xB0, then 2 more bytes, STOP → SDA_OE stays 0 throughout, no WR_DONE, memory unchanged.
- Sequential wrap: preload mem[0x7FF]=0x11, mem[0x000]=0x22; random read at 0x7FF (control 0xAE, addr 0xFF), master ACKs first byte → bytes 0x11 then 0x22.
- Mid-byte abort: START, 0xA0, 0x10, 4 bits of data, then STOP → no WR_DONE, mem[0x010] unchanged, state IDLE.
- Reset mid-read: RESET low for 1 CLK while slave drives a 0 bit → SDA_OE=0 next edge, BUSY=0, ptr=0. The next full write transaction succeeds.
